// File: rtl/dm_stage.sv
// Data-memory stage: 4 KiB word array with byte/half/word loads and stores, store counter and store log.
// Optional alignment checking is enabled by defining DM_ALIGN_CHECK_EN.
module dm_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid,
    input  logic [3:0]  memop,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic        exc,
    output logic [31:0] badvaddr,
    output logic [31:0] store_cnt
);

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    logic [31:0] r_mem [0:1023];
    logic [31:0] r_store_cnt;

    logic        w_is_lw, w_is_lh, w_is_lhu, w_is_sw, w_is_sh, w_is_sb;
    logic        w_is_store;
    logic        w_fault;
    logic        w_go;
    logic        w_commit;
    logic [9:0]  w_idx;
    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_be;
    logic [31:0] w_sdata;
    logic [31:0] w_new_word;

    assign w_is_lw    = (memop == OP_LW);
    assign w_is_lh    = (memop == OP_LH);
    assign w_is_lhu   = (memop == OP_LHU);
    assign w_is_sw    = (memop == OP_SW);
    assign w_is_sh    = (memop == OP_SH);
    assign w_is_sb    = (memop == OP_SB);
    assign w_is_store = w_is_sw || w_is_sh || w_is_sb;

`ifdef DM_ALIGN_CHECK_EN
    assign w_fault = valid &&
                     (((w_is_lw || w_is_sw) && (addr[1:0] != 2'b00)) ||
                      ((w_is_lh || w_is_lhu || w_is_sh) && addr[0]));
`else
    assign w_fault = 1'b0;
`endif

    assign w_go     = valid && !w_fault;
    assign w_commit = w_go && w_is_store;

    // Upper address bits are ignored, so the array aliases every 4 KiB.
    assign w_idx  = addr[11:2];
    assign w_word = r_mem[w_idx];

    always_comb begin
        w_byte = w_word[7:0];
        case (addr[1:0])
            2'd0: w_byte = w_word[7:0];
            2'd1: w_byte = w_word[15:8];
            2'd2: w_byte = w_word[23:16];
            2'd3: w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
    end

    assign w_half = addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        rdata = 32'd0;
        if (w_go) begin
            case (memop)
                OP_LW:   rdata = w_word;
                OP_LH:   rdata = {{16{w_half[15]}}, w_half};
                OP_LHU:  rdata = {16'd0, w_half};
                OP_LB:   rdata = {{24{w_byte[7]}}, w_byte};
                OP_LBU:  rdata = {24'd0, w_byte};
                default: rdata = 32'd0;
            endcase
        end
    end

    // Store data is replicated across lanes so byte enables alone pick the target.
    always_comb begin
        w_be    = 4'b0000;
        w_sdata = wdata;
        if (w_is_sw) begin
            w_be    = 4'b1111;
            w_sdata = wdata;
        end else if (w_is_sh) begin
            w_be    = addr[1] ? 4'b1100 : 4'b0011;
            w_sdata = {2{wdata[15:0]}};
        end else if (w_is_sb) begin
            w_be    = 4'b0001 << addr[1:0];
            w_sdata = {4{wdata[7:0]}};
        end
    end

    always_comb begin
        w_new_word = w_word;
        for (int b = 0; b < 4; b++) begin
            if (w_be[b]) w_new_word[b*8 +: 8] = w_sdata[b*8 +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 1024; i++) r_mem[i] <= 32'd0;
        end else if (w_commit) begin
            r_mem[w_idx] <= w_new_word;
`ifndef SYNTHESIS
            $display("%0t@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, w_new_word);
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_store_cnt <= 32'd0;
        end else if (w_commit) begin
            r_store_cnt <= r_store_cnt + 32'd1;
        end
    end

    assign store_cnt = r_store_cnt;

`ifdef DM_ALIGN_CHECK_EN
    logic        r_exc;
    logic [31:0] r_badvaddr;

    // A run of faulting accesses keeps exc high and refreshes badvaddr every edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_exc      <= 1'b0;
            r_badvaddr <= 32'd0;
        end else begin
            r_exc <= w_fault;
            if (w_fault) r_badvaddr <= addr;
        end
    end

    assign exc      = r_exc;
    assign badvaddr = r_badvaddr;
`else
    assign exc      = 1'b0;
    assign badvaddr = 32'd0;
`endif

endmodule

// File: tb/tb_dm_stage.sv
// Self-checking bench for dm_stage: directed scenarios plus random traffic against a byte-level memory model.
module tb_dm_stage;

    logic        clk;
    logic        reset;
    logic        valid;
    logic [3:0]  memop;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        exc;
    logic [31:0] badvaddr;
    logic [31:0] store_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q [$];

    // Reference state: flat byte memory plus counters.
    logic [7:0]  m8 [0:4095];
    logic [31:0] m_cnt;
    logic        m_exc;
    logic [31:0] m_badv;

    dm_stage dut (
        .clk       (clk),
        .reset     (reset),
        .valid     (valid),
        .memop     (memop),
        .addr      (addr),
        .wdata     (wdata),
        .pc        (pc),
        .rdata     (rdata),
        .exc       (exc),
        .badvaddr  (badvaddr),
        .store_cnt (store_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic void ref_clear();
        for (int i = 0; i < 4096; i++) m8[i] = 8'd0;
        m_cnt  = 32'd0;
        m_exc  = 1'b0;
        m_badv = 32'd0;
    endfunction

    function automatic bit ref_fault(input logic v, input logic [3:0] op, input logic [31:0] a);
`ifdef DM_ALIGN_CHECK_EN
        if (!v) return 0;
        if ((op == 4'd1 || op == 4'd6) && (a % 4 != 0)) return 1;
        if ((op == 4'd2 || op == 4'd3 || op == 4'd7) && (a % 2 != 0)) return 1;
        return 0;
`else
        return 0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic v, input logic [3:0] op, input logic [31:0] a);
        int b;
        longint val;
        b = int'(a % 4096);
        if (!v || ref_fault(v, op, a)) return 32'd0;
        case (op)
            4'd1: begin
                b = b - (b % 4);
                val = m8[b] + 256 * m8[b+1] + 65536 * m8[b+2] + 16777216 * longint'(m8[b+3]);
            end
            4'd2, 4'd3: begin
                b = b - (b % 2);
                val = m8[b] + 256 * m8[b+1];
                if (op == 4'd2 && val >= 32768) val = val - 65536;
            end
            4'd4, 4'd5: begin
                val = m8[b];
                if (op == 4'd4 && val >= 128) val = val - 256;
            end
            default: val = 0;
        endcase
        return val[31:0];
    endfunction

    function automatic void ref_edge(input logic v, input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] d);
        int b;
        bit f;
        f = ref_fault(v, op, a);
        m_exc = f;
        if (f) m_badv = a;
        if (!v || f) return;
        b = int'(a % 4096);
        case (op)
            4'd6: begin
                b = b - (b % 4);
                for (int k = 0; k < 4; k++) m8[b+k] = 8'((d >> (8 * k)) % 256);
                m_cnt = m_cnt + 1;
            end
            4'd7: begin
                b = b - (b % 2);
                m8[b]   = 8'(d % 256);
                m8[b+1] = 8'((d / 256) % 256);
                m_cnt = m_cnt + 1;
            end
            4'd8: begin
                m8[b] = 8'(d % 256);
                m_cnt = m_cnt + 1;
            end
            default: ;
        endcase
    endfunction

    // One access: present at negedge, check combinational read, clock it, check registered state.
    task automatic do_op(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] d, output logic [31:0] got);
        @(negedge clk);
        valid = v;
        memop = op;
        addr  = a;
        wdata = d;
        pc    = $urandom;
        #1;
        got = rdata;
        exp_q.push_back(ref_load(v, op, a));
        check("rdata", rdata, exp_q.pop_front());
        @(posedge clk);
        ref_edge(v, op, a, d);
        #1;
        check("store_cnt", store_cnt, m_cnt);
        check("exc", {31'd0, exc}, {31'd0, m_exc});
        check("badvaddr", badvaddr, m_badv);
    endtask

    logic [31:0] got;
    logic [31:0] ra;
    logic [3:0]  rop;
    logic        rv;

    initial begin
        reset = 1'b0;
        valid = 1'b0;
        memop = 4'd0;
        addr  = 32'd0;
        wdata = 32'd0;
        pc    = 32'd0;
        ref_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_store_cnt", store_cnt, 32'd0);
        check("rst_exc", {31'd0, exc}, 32'd0);
        check("rst_badvaddr", badvaddr, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        do_op(1, 4'd1, 32'h0, 32'h0, got);      check("lw_0", got, 32'h0);
        do_op(1, 4'd1, 32'hFFC, 32'h0, got);    check("lw_ffc", got, 32'h0);
        check("cnt_zero", store_cnt, 32'd0);

        do_op(1, 4'd6, 32'h10, 32'h12345678, got);
        do_op(1, 4'd4, 32'h11, 32'h0, got);     check("lb_11", got, 32'h00000056);
        do_op(1, 4'd2, 32'h12, 32'h0, got);     check("lh_12", got, 32'h00001234);
        do_op(1, 4'd8, 32'h13, 32'h000000AB, got);
        do_op(1, 4'd1, 32'h10, 32'h0, got);     check("lw_10", got, 32'hAB345678);
        do_op(1, 4'd5, 32'h13, 32'h0, got);     check("lbu_13", got, 32'h000000AB);
        do_op(1, 4'd4, 32'h13, 32'h0, got);     check("lb_13", got, 32'hFFFFFFAB);
        check("cnt_two", store_cnt, 32'd2);

        do_op(1, 4'd6, 32'h1004, 32'hDEADBEEF, got);
        do_op(1, 4'd1, 32'h4, 32'h0, got);      check("lw_wrap", got, 32'hDEADBEEF);
        do_op(0, 4'd6, 32'h4, 32'h11111111, got);
        do_op(1, 4'd1, 32'h4, 32'h0, got);      check("lw_novalid", got, 32'hDEADBEEF);
        check("cnt_novalid", store_cnt, 32'd3);

        do_op(1, 4'd6, 32'h20, 32'hCAFEF00D, got);
        do_op(1, 4'd7, 32'h21, 32'h00005AA5, got);
`ifdef DM_ALIGN_CHECK_EN
        check("sh21_exc", {31'd0, exc}, 32'd1);
        check("sh21_badv", badvaddr, 32'h21);
        do_op(1, 4'd1, 32'h20, 32'h0, got);     check("sh21_word", got, 32'hCAFEF00D);
        check("sh21_exc_drop", {31'd0, exc}, 32'd0);
`else
        check("sh21_exc", {31'd0, exc}, 32'd0);
        do_op(1, 4'd1, 32'h20, 32'h0, got);     check("sh21_word", got, 32'hCAFE5AA5);
`endif

        for (int i = 0; i < 400; i++) begin
            rv  = ($urandom_range(0, 7) != 0);
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom & 32'hFFFF_F03F;
            do_op(rv, rop, ra, $urandom, got);
        end

        // Counter wrap: preload the counter, then commit one byte store.
        @(negedge clk);
        force dut.r_store_cnt = 32'hFFFFFFFF;
        #1;
        release dut.r_store_cnt;
        m_cnt = 32'hFFFFFFFF;
        do_op(1, 4'd8, 32'h30, 32'h0000007E, got);
        check("cnt_wrap", store_cnt, 32'd0);

        // Asynchronous reset between edges.
        do_op(1, 4'd6, 32'h24, 32'h55AA55AA, got);
        @(negedge clk);
        valid = 1'b1; memop = 4'd1; addr = 32'h24;
        #1;
        check("pre_rst_rdata", rdata, 32'h55AA55AA);
        #1;
        reset = 1'b0;
        #1;
        check("async_rdata", rdata, 32'd0);
        check("async_cnt", store_cnt, 32'd0);
        check("async_exc", {31'd0, exc}, 32'd0);
        check("async_badv", badvaddr, 32'd0);
        ref_clear();
        @(negedge clk);
        reset = 1'b1;

        // Reset asserted while a store is presented: the store must not land.
        do_op(1, 4'd6, 32'h10, 32'h01020304, got);
        @(negedge clk);
        valid = 1'b1; memop = 4'd6; addr = 32'h10; wdata = 32'hFFFFFFFF;
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        valid = 1'b0;
        ref_clear();
        @(negedge clk);
        reset = 1'b1;
        do_op(1, 4'd1, 32'h10, 32'h0, got);     check("rst_midstore", got, 32'h0);
        check("rst_midstore_cnt", store_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dm_stage.md
DM_STAGE -- requirements
Module: dm_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately, independent of clk.
REQ-003 valid  input  1  memory-stage instruction valid; 0 = bubble, no state change.
REQ-004 memop  input  4  0 NONE, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; 9-15 treated as NONE.
REQ-005 addr  input  32  byte address (ALU result latched by the upstream EX/DM register).
REQ-006 wdata  input  32  store data, already forwarded; SH uses [15:0], SB uses [7:0].
REQ-007 pc  input  32  PC of the instruction in this stage, used only for store logging.
REQ-008 rdata  output  32  load result, extended to 32 bits.
REQ-009 exc  output  1  registered one-cycle alignment-fault pulse.
REQ-010 badvaddr  output  32  address of the most recent alignment fault, sticky.
REQ-011 store_cnt  output  32  count of committed stores.

Function
REQ-012 Storage SHALL be 1024 x 32-bit words (4 KiB), indexed by addr[11:2]; addr[31:12] is ignored (address wraps modulo 4 KiB).
REQ-013 rdata SHALL be combinational from the current array contents, with no added latency.
REQ-014 Load lane selection SHALL be: LB/LBU byte lane addr[1:0] (0 = bits 7:0); LH/LHU half lane addr[1] (0 = bits 15:0); LW whole word.
REQ-015 LB and LH SHALL sign-extend; LBU and LHU SHALL zero-extend.
REQ-016 rdata SHALL be 0 when valid=0, when memop is NONE or a store, or for a suppressed load.
REQ-017 A store SHALL commit at the rising edge when valid=1, memop is SW/SH/SB and the access is not suppressed.
REQ-018 SW writes all 4 bytes; SH writes half addr[1]; SB writes byte addr[1:0]; all unwritten bytes SHALL be preserved.
REQ-019 Read-during-write: an access in the same cycle as a store edge SHALL see the pre-store contents; the new data is visible the following cycle.
REQ-020 store_cnt SHALL increment by 1 per committed store and wrap from 0xFFFFFFFF to 0.
REQ-021 Simulation only: each committed store SHALL print "$time@pc: *word_addr <= new_full_word" (hex; word_addr = {addr[31:2],2'b00}).
REQ-022 exc SHALL be 1 for exactly one cycle following a faulting edge (REQ-026); otherwise 0.
REQ-023 Back-to-back faults SHALL keep exc high and update badvaddr each cycle.

Reset
REQ-024 While reset=0: all 1024 words = 0, store_cnt = 0, exc = 0, badvaddr = 0; rdata SHALL consequently read 0.
REQ-025 Reset asserted mid-store SHALL win: the array stays cleared and no log line is printed.

Configuration
REQ-026 With DM_ALIGN_CHECK_EN defined:
- Faulting accesses are LW/SW with addr[1:0]!=0 and LH/LHU/SH with addr[0]!=0, when valid=1.
- A faulting access SHALL be suppressed: no store, rdata 0, store_cnt unchanged.
- At the next edge exc<=1 and badvaddr<=addr.
REQ-027 Without DM_ALIGN_CHECK_EN:
- Word accesses SHALL ignore addr[1:0]; half accesses SHALL ignore addr[0].
- exc and badvaddr SHALL be constant 0.
- No access is suppressed.

Verification
REQ-028 Reset, then LW addr 0x0 and 0xFFC -> rdata 0; store_cnt 0.
REQ-029 SW 0x12345678 @0x10, then LB @0x11 -> 0x00000056; LH @0x12 -> 0x00001234; SB 0xAB @0x13, then LW @0x10 -> 0xAB345678; LBU @0x13 -> 0x000000AB; LB @0x13 -> 0xFFFFFFAB; store_cnt 2.
REQ-030 SW 0xDEADBEEF @0x1004 -> LW @0x4 returns 0xDEADBEEF (wrap); valid=0 with SW -> no change, no count.
REQ-031 With DM_ALIGN_CHECK_EN: SH @0x21 -> word 0x20 unchanged, exc=1 one cycle, badvaddr 0x21, store_cnt unchanged; without the macro the same SH writes half 0 of 0x20, exc=0.
REQ-032 Preload store_cnt to 0xFFFFFFFF via 2^32-1 stores (or force), commit one SB -> store_cnt 0; drop reset asynchronously between edges -> all outputs 0 before the next clk edge.
